i2s_rx: RTL and testbench

Audio ADC front end: deserialises a standard Philips I2S stream (bit clock, word select, serial data) into parallel signed stereo samples. It issues a one-cycle `sample_tick_o` per complete left/right pair. It is the producer side of the `sample_tick_i`/`data_i` sample interface consumed by `tremolo` and the other effect blocks. All logic runs in the fast system clock domain; the I2S pins are oversampled, never used as clocks.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 41 ++++
 rtl/i2s_rx.sv | 167 ++++++++++++++++
 tb/tb_i2s_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver (state encoding, synchroniser depth,
// slot bit-counter width helper).
package i2s_pkg;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

    localparam int I2S_SYNC_STAGES = 2;

    // Counter must reach SLOT_W+1 (saturation value), so it needs SLOT_W+2 codes.
    function automatic int bit_cnt_width(input int slot_w);
        return $clog2(slot_w + 2);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// N-stage synchroniser with a registered rising-edge strobe; q is delayed one extra
// flop so that it lines up with the cycle in which rise is high.
module sync_edge_detect
    import i2s_pkg::*;
#(
    parameter int   STAGES  = I2S_SYNC_STAGES,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] chain_r;
    logic              q_r;
    logic              rise_r;

    // Synchroniser chain, alignment flop and edge strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {STAGES{RST_VAL}};
            q_r     <= RST_VAL;
            rise_r  <= 1'b0;
        end else if (srst) begin
            chain_r <= {STAGES{RST_VAL}};
            q_r     <= RST_VAL;
            rise_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
            q_r     <= chain_r[STAGES-1];
            rise_r  <= chain_r[STAGES-1] & ~q_r;
        end
    end

    assign q    = q_r;
    assign rise = rise_r;

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples sck/ws/sd and emits signed stereo pairs with a
// one-cycle tick. Optional slot-length checking: define I2S_RX_FRAME_CHECK_EN.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DW     = 24,
    parameter int SLOT_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          sck_i,
    input  logic          ws_i,
    input  logic          sd_i,
    output logic [DW-1:0] left_o,
    output logic [DW-1:0] right_o,
    output logic          sample_tick_o,
    output logic          frame_err_o
);

    localparam int            CW       = bit_cnt_width(SLOT_W);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_W + 1);
    localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_W);

    logic          bit_stb_s;
    logic          ws_s;
    logic          sd_s;
    logic          sck_q_s;
    logic          ws_rise_s;
    logic          sd_rise_s;
    logic          unused_s;

    i2s_state_t    state_r;
    logic          ws_prev_r;
    logic [DW-1:0] shift_r;
    logic [CW-1:0] bit_cnt_r;
    logic [DW-1:0] left_hold_r;
    logic [DW-1:0] left_r;
    logic [DW-1:0] right_r;
    logic          tick_r;

    logic          bnd_s;
    logic [CW-1:0] cnt_next_s;
    logic [DW-1:0] word_s;
    logic          slot_ok_s;
    logic          err_set_s;

    sync_edge_detect #(.STAGES(I2S_SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk_i), .rst_n(rst_n_i), .srst(1'b0), .d(sck_i), .q(sck_q_s), .rise(bit_stb_s)
    );

    sync_edge_detect #(.STAGES(I2S_SYNC_STAGES), .RST_VAL(1'b1)) u_ws_sync (
        .clk(clk_i), .rst_n(rst_n_i), .srst(1'b0), .d(ws_i), .q(ws_s), .rise(ws_rise_s)
    );

    sync_edge_detect #(.STAGES(I2S_SYNC_STAGES), .RST_VAL(1'b0)) u_sd_sync (
        .clk(clk_i), .rst_n(rst_n_i), .srst(1'b0), .d(sd_i), .q(sd_s), .rise(sd_rise_s)
    );

    assign unused_s = sck_q_s ^ ws_rise_s ^ sd_rise_s;

    // Boundary detection, saturating count and the word including the current bit.
    always_comb begin
        bnd_s      = bit_stb_s & (ws_s != ws_prev_r);
        cnt_next_s = (bit_cnt_r == CNT_MAX) ? bit_cnt_r : bit_cnt_r + CW'(1);
        word_s     = shift_r;
        for (int i = 0; i < DW; i++) begin
            if (int'(bit_cnt_r) == DW - 1 - i) begin
                word_s[i] = sd_s;
            end else begin
                word_s[i] = shift_r[i];
            end
        end
`ifdef I2S_RX_FRAME_CHECK_EN
        slot_ok_s = (cnt_next_s == CNT_SLOT);
`else
        slot_ok_s = 1'b1;
`endif
        err_set_s = bnd_s & ((state_r == LEFT) | (state_r == RIGHT)) & ~slot_ok_s;
    end

    // Slot framing state machine with registered sample outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ALIGN;
            ws_prev_r   <= 1'b1;
            shift_r     <= {DW{1'b0}};
            bit_cnt_r   <= {CW{1'b0}};
            left_hold_r <= {DW{1'b0}};
            left_r      <= {DW{1'b0}};
            right_r     <= {DW{1'b0}};
            tick_r      <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (bit_stb_s) begin
                ws_prev_r <= ws_s;
                case (state_r)
                    ALIGN: begin
                        if (bnd_s && ws_prev_r) begin
                            shift_r   <= {DW{1'b0}};
                            bit_cnt_r <= {CW{1'b0}};
                            state_r   <= LEFT;
                        end
                    end
                    LEFT: begin
                        if (bnd_s) begin
                            shift_r   <= {DW{1'b0}};
                            bit_cnt_r <= {CW{1'b0}};
                            if (slot_ok_s) begin
                                left_hold_r <= word_s;
                                state_r     <= RIGHT;
                            end else begin
                                state_r <= ALIGN;
                            end
                        end else begin
                            shift_r   <= word_s;
                            bit_cnt_r <= cnt_next_s;
                        end
                    end
                    RIGHT: begin
                        if (bnd_s) begin
                            shift_r   <= {DW{1'b0}};
                            bit_cnt_r <= {CW{1'b0}};
                            if (slot_ok_s) begin
                                left_r  <= left_hold_r;
                                right_r <= word_s;
                                tick_r  <= 1'b1;
                                state_r <= LEFT;
                            end else begin
                                state_r <= ALIGN;
                            end
                        end else begin
                            shift_r   <= word_s;
                            bit_cnt_r <= cnt_next_s;
                        end
                    end
                    default: begin
                        state_r <= ALIGN;
                    end
                endcase
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic err_r;

    // Sticky slot-length error, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end
    end

    assign frame_err_o = err_r;
`else
    logic unused_err_s;
    assign unused_err_s = err_set_s;
    assign frame_err_o  = 1'b0;
`endif

    assign left_o        = left_r;
    assign right_o       = right_r;
    assign sample_tick_o = tick_r;

endmodule

// File: tb/tb_i2s_rx.sv
// Randomised scoreboard bench for i2s_rx; follows I2S_RX_FRAME_CHECK_EN for expectations.
module tb_i2s_rx;

    localparam int DW     = 24;
    localparam int SLOT_W = 32;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck   = 1'b0;
    logic          ws    = 1'b1;
    logic          sd    = 1'b0;
    logic [DW-1:0] left_o;
    logic [DW-1:0] right_o;
    logic          sample_tick_o;
    logic          frame_err_o;

    int            checks = 0;
    int            errors = 0;
    int            pushed = 0;
    int            ticks  = 0;
    int            half_ns = 40;
    bit            aligned = 1'b0;
    bit            err_exp = 1'b0;
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] exp_e;
    logic          tick_prev = 1'b0;

    i2s_rx #(.DW(DW), .SLOT_W(SLOT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .left_o(left_o), .right_o(right_o),
        .sample_tick_o(sample_tick_o), .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, required completion before 3ms");
        $fatal(1);
    end

    // Monitor: every tick must be one cycle wide and match the oldest expected pair.
    always @(negedge clk) begin
        if (sample_tick_o) begin
            ticks++;
            checks++;
            if (tick_prev) begin
                errors++;
                $display("FAIL tick_width: tick high in consecutive cycles, required 1-cycle pulse");
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got L=%h R=%h, required no tick", left_o, right_o);
            end else begin
                exp_e = exp_q.pop_front();
                checks++;
                if (left_o !== exp_e[2*DW-1:DW]) begin
                    errors++;
                    $display("FAIL left: got %h required %h", left_o, exp_e[2*DW-1:DW]);
                end
                checks++;
                if (right_o !== exp_e[DW-1:0]) begin
                    errors++;
                    $display("FAIL right: got %h required %h", right_o, exp_e[DW-1:0]);
                end
            end
        end
        tick_prev = sample_tick_o;
    end

    function automatic logic [63:0] trim(input logic [63:0] raw, input int n);
        logic [63:0] ones;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        return raw & ~(ones >> n);
    endfunction

    task automatic send_bit(input logic w, input logic b);
        ws = w;
        sd = b;
        #(half_ns);
        sck = 1'b1;
        #(half_ns);
        sck = 1'b0;
    endtask

    // The last bit of a slot is sent with ws already showing the next channel.
    task automatic send_slot(input logic ch, input logic [63:0] data, input int n);
        for (int k = 0; k < n; k++) begin
            send_bit((k == n - 1) ? ~ch : ch, data[63-k]);
        end
    endtask

    task automatic rephase();
        @(posedge clk);
        #($urandom_range(9, 1));
    endtask

    task automatic preamble(input int n);
        send_slot(1'b1, trim({$urandom, $urandom}, n), n);
        aligned = 1'b1;
    endtask

    // Reference: a pair is emitted only if the receiver is locked and both slots are
    // acceptable; a bad right slot costs the following pair too (relock needs R->L).
    task automatic send_pair(input logic [63:0] lw, input int nl,
                             input logic [63:0] rw, input int nr);
        bit ok_l;
        bit ok_r;
        bit next_aligned;
        ok_l = !CHECK || (nl == SLOT_W);
        ok_r = !CHECK || (nr == SLOT_W);
        if (aligned && ok_l && ok_r) begin
            exp_q.push_back({lw[63 -: DW], rw[63 -: DW]});
            pushed++;
        end
        if (aligned && !(ok_l && ok_r)) err_exp = 1'b1;
        next_aligned = !(aligned && ok_l && !ok_r);
        send_slot(1'b0, lw, nl);
        send_slot(1'b1, rw, nr);
        aligned = next_aligned;
    endtask

    task automatic rand_pair();
        int nl;
        int nr;
        nl = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 16)) : SLOT_W;
        nr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 16)) : SLOT_W;
        send_pair(trim({$urandom, $urandom}, nl), nl, trim({$urandom, $urandom}, nr), nr);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d pairs still pending, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (frame_err_o !== err_exp) begin
            errors++;
            $display("FAIL %s_frame_err: got %b required %b", tag, frame_err_o, err_exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (left_o !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL %s_left: got %h required 0", tag, left_o);
        end
        checks++;
        if (right_o !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL %s_right: got %h required 0", tag, right_o);
        end
        checks++;
        if (sample_tick_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_tick: got %b required 0", tag, sample_tick_o);
        end
        checks++;
        if (frame_err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_err: got %b required 0", tag, frame_err_o);
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed patterns at clk = 8 x sck, starting mid-way through a right slot.
        half_ns = 40;
        rephase();
        preamble(10);
        send_pair({24'h7FFFFF, 40'h0}, 32, {24'h800001, 40'h0}, 32);
        send_pair({16'h1234, 48'h0}, 16, {16'hABCD, 48'h0}, 16);
        send_pair(trim({$urandom, $urandom}, 31), 31, trim({$urandom, $urandom}, 32), 32);
        send_pair(trim({$urandom, $urandom}, 32), 32, trim({$urandom, $urandom}, 32), 32);
        drain("directed");

        // Reset in the middle of a left slot.
        for (int k = 0; k < 12; k++) send_bit(1'b0, 1'($urandom_range(1, 0)));
        #7;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        aligned = 1'b0;
        err_exp = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Minimum oversampling ratio with random phase and random slot lengths.
        half_ns = 20;
        rephase();
        preamble(int'($urandom_range(31, 5)));
        send_pair({24'h000001, 40'h0}, 32, {24'hFFFFFF, 40'h0}, 32);
        for (int p = 0; p < 250; p++) begin
            if ($urandom_range(7, 0) == 0) rephase();
            rand_pair();
        end
        drain("random");

        checks++;
        if (ticks != pushed) begin
            errors++;
            $display("FAIL tick_count: got %0d required %0d", ticks, pushed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
